// File: rtl/iob_soc_sut_rst_seq_pkg.sv
// Shared definitions for the iob_soc_sut reset sequencer.
package iob_soc_sut_rst_seq_pkg;

  localparam int unsigned STATE_W = 3;

  // Encoding is visible on state_o (debug LEDs), so values are fixed.
  typedef enum logic [STATE_W-1:0] {
    S_LOCK    = 3'd0,
    S_INIT    = 3'd1,
    S_STRETCH = 3'd2,
    S_RUN     = 3'd3,
    S_FAIL    = 3'd4
  } state_e;

  // Bit positions inside the synchronised input bus.
  localparam int unsigned SYNC_W      = 3;
  localparam int unsigned SYNC_LOCKED = 0;
  localparam int unsigned SYNC_INIT   = 1;
  localparam int unsigned SYNC_CAL    = 2;

  // States in which the bring-up timeout counter advances.
  function automatic logic is_bringup(state_e s);
    return (s == S_LOCK) || (s == S_INIT) || (s == S_STRETCH);
  endfunction

endpackage

// File: rtl/iob_sync_bus.sv
// Multi-bit level synchroniser: each bit passes SYNC_STAGES flops, reset to 0.
module iob_sync_bus #(
  parameter int unsigned W           = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         clk_i,
  input  logic         arst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [SYNC_STAGES-1:0][W-1:0] r_sync;

  // Shift chain; stage 0 samples the asynchronous inputs.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/iob_soc_sut_rst_seq.sv
// Reset sequencer for iob_soc_sut: waits for PLL lock (and DDR3 init when
// EXTMEM), stretches reset, then releases; latches calibration failure.
module iob_soc_sut_rst_seq
  import iob_soc_sut_rst_seq_pkg::*;
#(
  parameter int unsigned EXTMEM         = 1,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned STRETCH_CYCLES = 16,
  parameter int unsigned TIMEOUT_W      = 24
) (
  input  logic               clk_i,
  input  logic               arst_i,
  input  logic               pll_locked_i,
  input  logic               init_done_i,
  input  logic               cal_fail_i,
  output logic               sys_rst_o,
  output logic [STATE_W-1:0] state_o,
  output logic               timeout_o,
  output logic               fail_o
);

  localparam int unsigned STRETCH_W = $clog2(STRETCH_CYCLES + 1);
  localparam logic [STRETCH_W-1:0] STRETCH_LAST = STRETCH_W'(STRETCH_CYCLES - 1);

  logic [SYNC_W-1:0]    w_sync;
  logic                 w_locked_s;
  logic                 w_init_done_s;
  logic                 w_cal_fail_s;

  state_e               r_state;
  state_e               w_state_d;
  logic [STRETCH_W-1:0] r_stretch;
  logic [STRETCH_W-1:0] w_stretch_d;
  logic [TIMEOUT_W-1:0] r_tmo;
  logic [TIMEOUT_W-1:0] w_tmo_d;
  logic                 r_sys_rst;
  logic                 r_fail;

  iob_sync_bus #(
    .W           (SYNC_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .d_i    ({cal_fail_i, init_done_i, pll_locked_i}),
    .q_o    (w_sync)
  );

  // Without external memory only PLL lock matters.
  assign w_locked_s    = w_sync[SYNC_LOCKED];
  assign w_init_done_s = (EXTMEM != 0) ? w_sync[SYNC_INIT] : 1'b1;
  assign w_cal_fail_s  = (EXTMEM != 0) ? w_sync[SYNC_CAL]  : 1'b0;

  // Next-state, stretch counter and timeout counter.
  always_comb begin
    w_state_d   = r_state;
    w_stretch_d = r_stretch;
    unique case (r_state)
      S_LOCK: begin
        if (w_locked_s) w_state_d = (EXTMEM != 0) ? S_INIT : S_STRETCH;
      end
      S_INIT: begin
        if (w_cal_fail_s)       w_state_d = S_FAIL;
        else if (!w_locked_s)   w_state_d = S_LOCK;
        else if (w_init_done_s) w_state_d = S_STRETCH;
      end
      S_STRETCH: begin
        if (w_cal_fail_s) begin
          w_state_d   = S_FAIL;
          w_stretch_d = '0;
        end else if (!w_locked_s || !w_init_done_s) begin
          w_state_d   = S_LOCK;
          w_stretch_d = '0;
        end else if (r_stretch == STRETCH_LAST) begin
          w_state_d   = S_RUN;
          w_stretch_d = '0;
        end else begin
          w_stretch_d = r_stretch + STRETCH_W'(1);
        end
      end
      S_RUN: begin
        if (w_cal_fail_s)                       w_state_d = S_FAIL;
        else if (!w_locked_s || !w_init_done_s) w_state_d = S_LOCK;
      end
      S_FAIL: w_state_d = S_FAIL;
      default: w_state_d = S_LOCK;
    endcase

    // Timeout only reports; it never influences the state machine.
    w_tmo_d = r_tmo;
    if ((w_state_d == S_RUN) && (r_state != S_RUN)) begin
      w_tmo_d = '0;
    end else if (is_bringup(r_state) && !(&r_tmo)) begin
      w_tmo_d = r_tmo + TIMEOUT_W'(1);
    end
  end

  // State and registered outputs; reset released on the edge that enters S_RUN.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state   <= S_LOCK;
      r_stretch <= '0;
      r_tmo     <= '0;
      r_sys_rst <= 1'b1;
      r_fail    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_stretch <= w_stretch_d;
      r_tmo     <= w_tmo_d;
      r_sys_rst <= (w_state_d != S_RUN);
      r_fail    <= r_fail | (w_state_d == S_FAIL);
    end
  end

  assign sys_rst_o = r_sys_rst;
  assign state_o   = r_state;
  assign timeout_o = &r_tmo;
  assign fail_o    = r_fail;

endmodule
